mux_scan_ctrl: RTL and testbench

//   Sequencer directly upstream/downstream of the 1-bit 4:1 select mux. Drives the
//   mux select lines {s1,s0} through the enabled channels, waits a settle time, and

---
 rtl/mux_scan_if.sv | 32 +++
 rtl/mux_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// Frame-scan bus between mux_scan_ctrl and its mux/consumer side.
// With SCAN_PARITY_EN defined the bus also carries frame_par.
interface mux_scan_if;
  logic       scan_en;
  logic [3:0] ch_mask;
  logic       s0;
  logic       s1;
  logic       y;
  logic [3:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic       busy;
`ifdef SCAN_PARITY_EN
  logic       frame_par;
`endif

  modport master (
    input  scan_en, ch_mask, y, frame_ready,
    output s0, s1, frame, frame_valid, busy
`ifdef SCAN_PARITY_EN
    , output frame_par
`endif
  );

  modport slave (
    output scan_en, ch_mask, y, frame_ready,
    input  s0, s1, frame, frame_valid, busy
`ifdef SCAN_PARITY_EN
    , input frame_par
`endif
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled channels of a 4:1 mux and delivers the samples as a 4-bit frame.
// Optional feature macro: SCAN_PARITY_EN adds a registered frame_par = ^frame.
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input logic      clk,
  input logic      rst_n,
  mux_scan_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, OUTPUT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_mask_q;
  logic [3:0]       r_shadow;
  logic [3:0]       r_frame;
  logic             r_frame_valid;
  logic [1:0]       r_ch;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       w_above;
  logic             w_start;
  logic             w_sample;
  logic             w_load_frame;
`ifdef SCAN_PARITY_EN
  logic             r_frame_par;
`endif

  function automatic logic [1:0] low_bit(input logic [3:0] m);
    logic [1:0] lb;
    lb = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lb = 2'(i);
    end
    return lb;
  endfunction

  // Mask bits strictly above ch; 2<<3 wraps to 0 in 4 bits, leaving nothing above channel 3.
  function automatic logic [3:0] bits_above(input logic [3:0] m, input logic [1:0] ch);
    logic [3:0] thr;
    thr = (4'd2 << ch) - 4'd1;
    return m & ~thr;
  endfunction

  assign w_above = bits_above(r_mask_q, r_ch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_sample     = 1'b0;
    w_load_frame = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.scan_en && (bus.ch_mask != 4'd0)) begin
          w_start     = 1'b1;
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == CNT_W'(1)) w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        w_sample    = 1'b1;
        w_state_nxt = (w_above != 4'd0) ? SETTLE : OUTPUT;
      end
      OUTPUT: begin
        if (!r_frame_valid || bus.frame_ready) begin
          w_load_frame = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask_q <= 4'd0;
      r_shadow <= 4'd0;
      r_ch     <= 2'd0;
      r_cnt    <= '0;
    end else if (w_start) begin
      r_mask_q <= bus.ch_mask;
      r_shadow <= 4'd0;
      r_ch     <= low_bit(bus.ch_mask);
      r_cnt    <= CNT_W'(SETTLE_CYCLES);
    end else if (r_state == SETTLE) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (w_sample) begin
      r_shadow[r_ch] <= bus.y;
      if (w_above != 4'd0) begin
        r_ch  <= low_bit(w_above);
        r_cnt <= CNT_W'(SETTLE_CYCLES);
      end
    end
  end

  // A load in the same cycle as a transfer keeps valid high with the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame       <= 4'd0;
      r_frame_valid <= 1'b0;
`ifdef SCAN_PARITY_EN
      r_frame_par   <= 1'b0;
`endif
    end else if (w_load_frame) begin
      r_frame       <= r_shadow;
      r_frame_valid <= 1'b1;
`ifdef SCAN_PARITY_EN
      r_frame_par   <= ^r_shadow;
`endif
    end else if (r_frame_valid && bus.frame_ready) begin
      r_frame_valid <= 1'b0;
    end
  end

  assign bus.s0          = r_ch[0];
  assign bus.s1          = r_ch[1];
  assign bus.frame       = r_frame;
  assign bus.frame_valid = r_frame_valid;
  assign bus.busy        = (r_state != IDLE);
`ifdef SCAN_PARITY_EN
  assign bus.frame_par   = r_frame_par;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: stimulus queues expected frames, a monitor checks transfers.
module tb_mux_scan_ctrl;
  logic clk;
  logic rst_n;
  logic [3:0] d;
  int total;
  int bad;
  logic [3:0] q[$];

  mux_scan_if bus();

  mux_scan_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  // Model of the 1-bit 4:1 mux being scanned.
  assign bus.y = d[{bus.s1, bus.s0}];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.frame_valid && bus.frame_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got=0x%0h expected=no frame", bus.frame);
      end else begin
        logic [3:0] e;
        e = q.pop_front();
        check("frame", 32'(bus.frame), 32'(e));
`ifdef SCAN_PARITY_EN
        check("frame_par", 32'(bus.frame_par), 32'(^e));
`endif
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((bus.busy || bus.frame_valid) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_idle"}, 32'(bus.busy || bus.frame_valid), 32'd0);
  endtask

  // Starts one scan; edge 0 is the edge that samples scan_en=1 in IDLE.
  task automatic run_scan(input string nm, input logic [3:0] m, input logic [3:0] dv,
                          input logic [3:0] exp_frame, input int exp_lat, input int chg_at,
                          output logic [47:0] seqv);
    logic [3:0] visited;
    int lat;
    d = dv;
    bus.ch_mask = m;
    bus.scan_en = 1'b1;
    q.push_back(exp_frame);
    seqv = '0;
    visited = 4'd0;
    lat = -1;
    @(posedge clk); #1;
    if (chg_at == 0) bus.scan_en = 1'b0;
    seqv[1:0] = {bus.s1, bus.s0};
    if (bus.busy) visited[{bus.s1, bus.s0}] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k < 24) seqv[2*k +: 2] = {bus.s1, bus.s0};
      if (bus.busy) visited[{bus.s1, bus.s0}] = 1'b1;
      if (k == chg_at) begin
        bus.ch_mask = 4'b0001;
        bus.scan_en = 1'b0;
      end
      if (bus.frame_valid) begin
        lat = k;
        break;
      end
    end
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_visited"}, 32'(visited), 32'(m));
  endtask

  initial begin
    logic [47:0] seqv;
    logic [23:0] exp_seq;
    int hold_bad;
    int n;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    d = 4'd0;
    bus.scan_en = 1'b0;
    bus.ch_mask = 4'd0;
    bus.frame_ready = 1'b1;
    #1;
    check("rst_sel", 32'({bus.s1, bus.s0}), 32'd0);
    check("rst_frame", 32'(bus.frame), 32'd0);
    check("rst_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_en_busy", 32'(bus.busy), 32'd0);

    // Full scan: selects 0,1,2,3 each held 3 edges, frame at edge 13.
    run_scan("full", 4'b1111, 4'b1010, 4'b1010, 13, 0, seqv);
    for (int k = 0; k < 12; k++) exp_seq[2*k +: 2] = 2'(k / 3);
    check("full_sel_seq", 32'(seqv[23:0]), 32'(exp_seq));
    wait_idle("full");

    // Masked scan: only channels 0 and 2.
    run_scan("masked", 4'b0101, 4'b1111, 4'b0101, 7, 0, seqv);
    wait_idle("masked");

    // Back-pressure with scan_en held: second frame must wait for the first transfer.
    bus.frame_ready = 1'b0;
    d = 4'b1010;
    bus.ch_mask = 4'b1111;
    bus.scan_en = 1'b1;
    q.push_back(4'b1010);
    n = 0;
    while (!bus.frame_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_first_latency", 32'(n), 32'd14);
    d = 4'b0110;
    q.push_back(4'b0110);
    @(posedge clk); #1;
    bus.scan_en = 1'b0;
    hold_bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.frame !== 4'b1010 || bus.frame_valid !== 1'b1) hold_bad++;
    end
    check("bp_hold", 32'(hold_bad), 32'd0);
    check("bp_stalled_busy", 32'(bus.busy), 32'd1);
    bus.frame_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_second_frame", 32'(bus.frame), 32'b0110);
    wait_idle("bp");

    // Mask/enable change mid-scan: frame still covers all channels.
    run_scan("midchg", 4'b1111, 4'b1001, 4'b1001, 13, 4, seqv);
    wait_idle("midchg");

    // Parity vectors (frame=0111 and frame=1010).
    run_scan("par0111", 4'b1111, 4'b0111, 4'b0111, 13, 0, seqv);
    wait_idle("par0111");

    // Asynchronous reset in the middle of a scan.
    d = 4'b1111;
    bus.ch_mask = 4'b1111;
    bus.scan_en = 1'b1;
    @(posedge clk); #1;
    bus.scan_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs",
          32'({bus.s1, bus.s0, bus.frame, bus.frame_valid, bus.busy}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    // Single enabled channel.
    run_scan("single", 4'b1000, 4'b1000, 4'b1000, 4, 0, seqv);
    wait_idle("single");

    @(posedge clk); #1;
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
